// File: rtl/rtc_access_scheduler.sv
// rtc_access_scheduler: arbitrates the shared RTC bus between init, read and write FSMs
module rtc_access_scheduler #(
  parameter int READ_PERIOD = 100000,
  parameter int TIMEOUT = 1023,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_escribir,
  input  logic       clr_error,
  input  logic       fin_init,
  input  logic       fin_leer,
  input  logic       fin_escribir,
  output logic       do_it_init,
  output logic       do_it_leer,
  output logic       do_it_escribir,
  output logic [1:0] bus_owner,
  output logic       ack_escribir,
  output logic       error_timeout,
  output logic       busy
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LEER, S_ESC, S_GAP} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [TO_W-1:0] r_to;
  logic [GAP_W-1:0] r_gap;
  logic r_pend_r, r_pend_w, r_last_w;
  logic w_tick, w_grant_any, w_fin, w_abort, w_grant_r, w_grant_w;
  assign w_tick = r_cnt == CNT_W'(READ_PERIOD - 1);
  assign w_grant_any = do_it_init | do_it_leer | do_it_escribir;
  // a fin pulse only counts while its own grant is actually up
  assign w_fin = (fin_init & do_it_init) | (fin_leer & do_it_leer) | (fin_escribir & do_it_escribir);
  assign w_abort = w_grant_any & ~w_fin & (r_to == TO_W'(TIMEOUT - 1));
  assign w_grant_w = (r_state == S_IDLE) && (w_next == S_ESC);
  assign w_grant_r = (r_state == S_IDLE) && (w_next == S_LEER);
  // next-state selection: alternating priority in IDLE, fin/timeout exits from grant states
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT, S_LEER, S_ESC: w_next = (w_fin | w_abort) ? S_GAP : r_state;
      S_IDLE: w_next = (r_pend_w && (!r_pend_r || !r_last_w)) ? S_ESC : r_pend_r ? S_LEER : S_IDLE;
      S_GAP: w_next = (r_gap == GAP_W'(GAP_CYCLES - 1)) ? S_IDLE : S_GAP;
      default: w_next = S_INIT;
    endcase
  end
  // state plus outputs registered from the next state so grants are glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
      do_it_init <= 1'b0;
      do_it_leer <= 1'b0;
      do_it_escribir <= 1'b0;
      bus_owner <= 2'b00;
      busy <= 1'b0;
      ack_escribir <= 1'b0;
      error_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      do_it_init <= w_next == S_INIT;
      do_it_leer <= w_next == S_LEER;
      do_it_escribir <= w_next == S_ESC;
      bus_owner <= w_next == S_INIT ? 2'b11 : w_next == S_ESC ? 2'b10 : w_next == S_LEER ? 2'b01 : 2'b00;
      busy <= w_next != S_IDLE;
      ack_escribir <= fin_escribir & do_it_escribir;
      error_timeout <= w_abort | (error_timeout & ~clr_error);
    end
  end
  // period, timeout and gap counters plus request latches (set beats clear)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_to <= '0;
      r_gap <= '0;
      r_pend_r <= 1'b0;
      r_pend_w <= 1'b0;
      r_last_w <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      r_to <= (w_grant_any && w_next == r_state) ? r_to + 1'b1 : '0;
      r_gap <= r_state == S_GAP ? r_gap + 1'b1 : '0;
      r_pend_r <= w_tick | (r_pend_r & ~w_grant_r);
      r_pend_w <= req_escribir | (r_pend_w & ~w_grant_w);
      r_last_w <= w_grant_w ? 1'b1 : w_grant_r ? 1'b0 : r_last_w;
    end
  end
endmodule

// File: tb/tb_rtc_access_scheduler.sv
// tb_rtc_access_scheduler: directed checks of grants, priority, timeout and reset
module tb_rtc_access_scheduler;
  logic clk = 1'b0, reset = 1'b0;
  logic req_escribir = 1'b0, clr_error = 1'b0, fin_init = 1'b0, fin_leer = 1'b0, fin_escribir = 1'b0;
  logic do_it_init, do_it_leer, do_it_escribir, ack_escribir, error_timeout, busy;
  logic [1:0] bus_owner;
  logic [7:0] obs, exp;
  int cyc, checks = 0, errors = 0;
  localparam logic [7:0] IDLE = 8'b00000000, INIT = 8'b10011001, LEER = 8'b01001001;
  localparam logic [7:0] ESC = 8'b00110001, GAP = 8'b00000001, ACK = 8'b00000101, ERR = 8'b00000010;
  rtc_access_scheduler #(.READ_PERIOD(50), .TIMEOUT(20), .GAP_CYCLES(2), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .req_escribir(req_escribir), .clr_error(clr_error),
    .fin_init(fin_init), .fin_leer(fin_leer), .fin_escribir(fin_escribir),
    .do_it_init(do_it_init), .do_it_leer(do_it_leer), .do_it_escribir(do_it_escribir),
    .bus_owner(bus_owner), .ack_escribir(ack_escribir), .error_timeout(error_timeout), .busy(busy)
  );
  assign obs = {do_it_init, do_it_leer, do_it_escribir, bus_owner, ack_escribir, error_timeout, busy};
  always #5 clk = ~clk;
  always @(posedge clk or negedge reset) cyc <= !reset ? 0 : cyc + 1;
  task automatic go(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL reset_outputs: got %b exp %b", obs, exp); end
    #2 reset = 1'b1;
    #1 exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL pre_first_edge: got %b exp %b", obs, exp); end
  endtask
  task automatic test_init;
    go(1); exp = INIT; checks++; if (obs !== exp) begin errors++; $display("FAIL init_c1: got %b exp %b", obs, exp); end
    go(5); exp = INIT; checks++; if (obs !== exp) begin errors++; $display("FAIL init_c5: got %b exp %b", obs, exp); end
    fin_init = 1'b1;
    go(6); fin_init = 1'b0;
    exp = GAP; checks++; if (obs !== exp) begin errors++; $display("FAIL init_gap1: got %b exp %b", obs, exp); end
    go(7); exp = GAP; checks++; if (obs !== exp) begin errors++; $display("FAIL init_gap2: got %b exp %b", obs, exp); end
    go(8); exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL init_idle: got %b exp %b", obs, exp); end
  endtask
  task automatic test_periodic_read;
    go(50); exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL tick_idle: got %b exp %b", obs, exp); end
    go(51); exp = LEER; checks++; if (obs !== exp) begin errors++; $display("FAIL tick_leer: got %b exp %b", obs, exp); end
    go(53); fin_leer = 1'b1;
    go(54); fin_leer = 1'b0;
    exp = GAP; checks++; if (obs !== exp) begin errors++; $display("FAIL read_gap: got %b exp %b", obs, exp); end
    go(56); exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL read_idle: got %b exp %b", obs, exp); end
  endtask
  task automatic test_write;
    go(60); req_escribir = 1'b1;
    go(61); req_escribir = 1'b0;
    exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL wr_latency: got %b exp %b", obs, exp); end
    for (int c = 62; c <= 71; c++) begin
      go(c); exp = ESC; checks++; if (obs !== exp) begin errors++; $display("FAIL wr_grant c%0d: got %b exp %b", c, obs, exp); end
    end
    fin_escribir = 1'b1;
    go(72); fin_escribir = 1'b0;
    exp = ACK; checks++; if (obs !== exp) begin errors++; $display("FAIL wr_ack: got %b exp %b", obs, exp); end
    go(73); exp = GAP; checks++; if (obs !== exp) begin errors++; $display("FAIL wr_ack_once: got %b exp %b", obs, exp); end
    go(74); exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL wr_idle: got %b exp %b", obs, exp); end
  endtask
  task automatic test_back_to_back;
    go(101); exp = LEER; checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_read0: got %b exp %b", obs, exp); end
    go(102); fin_leer = 1'b1;
    go(103); fin_leer = 1'b0;
    go(149); req_escribir = 1'b1;
    go(150); req_escribir = 1'b0;
    exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_idle: got %b exp %b", obs, exp); end
    go(151); exp = ESC; checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_write_first: got %b exp %b", obs, exp); end
    go(153); fin_escribir = 1'b1;
    go(154); fin_escribir = 1'b0;
    exp = ACK; checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_ack: got %b exp %b", obs, exp); end
    go(156); exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_gap_end: got %b exp %b", obs, exp); end
    go(157); exp = LEER; checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_read_next: got %b exp %b", obs, exp); end
    go(158); req_escribir = 1'b1;
    go(159); req_escribir = 1'b0;
    exp = LEER; checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_read_held: got %b exp %b", obs, exp); end
    go(160); fin_leer = 1'b1;
    go(161); fin_leer = 1'b0;
    exp = GAP; checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_gap2: got %b exp %b", obs, exp); end
    go(163); exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_idle2: got %b exp %b", obs, exp); end
    go(164); exp = ESC; checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_write_after: got %b exp %b", obs, exp); end
    go(165); fin_escribir = 1'b1;
    go(166); fin_escribir = 1'b0;
    exp = ACK; checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_ack2: got %b exp %b", obs, exp); end
  endtask
  task automatic test_timeout;
    go(200); exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL to_idle: got %b exp %b", obs, exp); end
    go(201); exp = LEER; checks++; if (obs !== exp) begin errors++; $display("FAIL to_grant: got %b exp %b", obs, exp); end
    go(220); exp = LEER; checks++; if (obs !== exp) begin errors++; $display("FAIL to_last_cycle: got %b exp %b", obs, exp); end
    go(221); exp = GAP | ERR; checks++; if (obs !== exp) begin errors++; $display("FAIL to_abort: got %b exp %b", obs, exp); end
    go(223); exp = ERR; checks++; if (obs !== exp) begin errors++; $display("FAIL to_idle_err: got %b exp %b", obs, exp); end
    go(230); exp = ERR; checks++; if (obs !== exp) begin errors++; $display("FAIL to_sticky: got %b exp %b", obs, exp); end
    clr_error = 1'b1;
    go(231); clr_error = 1'b0;
    exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL to_clear: got %b exp %b", obs, exp); end
  endtask
  task automatic test_reset_during_write;
    go(235); req_escribir = 1'b1;
    go(236); req_escribir = 1'b0;
    go(237); exp = ESC; checks++; if (obs !== exp) begin errors++; $display("FAIL rst_pre_write: got %b exp %b", obs, exp); end
    go(240); reset = 1'b0;
    #1 exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL rst_async: got %b exp %b", obs, exp); end
    @(posedge clk); #1 exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL rst_held: got %b exp %b", obs, exp); end
    #2 reset = 1'b1;
    go(1); exp = INIT; checks++; if (obs !== exp) begin errors++; $display("FAIL rst_init: got %b exp %b", obs, exp); end
    go(3); fin_init = 1'b1;
    go(4); fin_init = 1'b0;
    exp = GAP; checks++; if (obs !== exp) begin errors++; $display("FAIL rst_gap: got %b exp %b", obs, exp); end
    for (int c = 6; c <= 12; c++) begin
      go(c); exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL rst_pend_lost c%0d: got %b exp %b", c, obs, exp); end
    end
  endtask
  task automatic test_ignore_fin;
    go(51); exp = LEER; checks++; if (obs !== exp) begin errors++; $display("FAIL ign_grant: got %b exp %b", obs, exp); end
    go(52); fin_escribir = 1'b1; fin_init = 1'b1;
    go(53); fin_escribir = 1'b0; fin_init = 1'b0;
    exp = LEER; checks++; if (obs !== exp) begin errors++; $display("FAIL ign_foreign_fin: got %b exp %b", obs, exp); end
    go(54); exp = LEER; checks++; if (obs !== exp) begin errors++; $display("FAIL ign_no_ack: got %b exp %b", obs, exp); end
    go(56); fin_leer = 1'b1;
    exp = LEER; checks++; if (obs !== exp) begin errors++; $display("FAIL ign_still_leer: got %b exp %b", obs, exp); end
    go(57); fin_leer = 1'b0; fin_escribir = 1'b1;
    exp = GAP; checks++; if (obs !== exp) begin errors++; $display("FAIL ign_drop: got %b exp %b", obs, exp); end
    go(58); fin_escribir = 1'b0;
    exp = GAP; checks++; if (obs !== exp) begin errors++; $display("FAIL ign_gap_fin: got %b exp %b", obs, exp); end
    go(59); exp = IDLE; checks++; if (obs !== exp) begin errors++; $display("FAIL ign_idle: got %b exp %b", obs, exp); end
  endtask
  initial begin
    test_reset;
    test_init;
    test_periodic_read;
    test_write;
    test_back_to_back;
    test_timeout;
    test_reset_during_write;
    test_ignore_fin;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
